// File: rtl/zclk_pkg.sv
// Shared turbo-mode encodings for the CPU clock generator, Z80 bus interface and arbiter.
package zclk_pkg;

  typedef logic [1:0] turbo_t;

  localparam turbo_t TURBO_3M5 = 2'b00;
  localparam turbo_t TURBO_7M  = 2'b01;
  localparam turbo_t TURBO_14M = 2'b10;

  // 2'b11 is an alias of 14 MHz; fold it on load so turbo_cur only reports legal modes.
  function automatic turbo_t turbo_norm(input turbo_t t);
    return t[1] ? TURBO_14M : t;
  endfunction

endpackage

// File: rtl/zclk_gen.sv
// Z80 CPU clock generator: 3.5/7/14 MHz clock pin plus edge strobes, stall hold, glitch-free turbo switch.
// Optional contended-memory hold enabled by defining ZCLK_CONTEND_EN.
module zclk_gen
  import zclk_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       c1,
  input  logic       c3,
  input  logic [1:0] turbo,
  input  logic       zstall,
  input  logic       cont,
  input  logic       cont_win,
  output logic       zclk_out,
  output logic       zpos,
  output logic       zneg,
  output logic [1:0] turbo_cur
);

  logic   zclk_q, zclk_d;
  turbo_t turbo_q, turbo_d;
  logic   te;
  logic   hold;
  logic   cont_hold;

`ifdef ZCLK_CONTEND_EN
  assign cont_hold = cont & cont_win & (turbo_q == TURBO_3M5);
`else
  logic unused_cont;
  assign unused_cont = cont ^ cont_win;
  assign cont_hold   = 1'b0;
`endif

  assign hold = zstall | cont_hold;

  always_comb begin
    te = 1'b1;
    case (turbo_q)
      TURBO_3M5: te = c1;
      TURBO_7M:  te = c1 | c3;
      default:   te = 1'b1;
    endcase
  end

  // Hold only blocks the falling edge, so a low phase always runs to completion.
  always_comb begin
    zpos = rst_n & te & ~zclk_q;
    zneg = rst_n & te & zclk_q & ~hold;
  end

  always_comb begin
    zclk_d  = zclk_q ^ (zpos | zneg);
    turbo_d = zpos ? turbo_norm(turbo) : turbo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zclk_q  <= 1'b1;
      turbo_q <= TURBO_3M5;
    end else begin
      zclk_q  <= zclk_d;
      turbo_q <= turbo_d;
    end
  end

  assign zclk_out  = zclk_q;
  assign turbo_cur = turbo_q;

endmodule

// File: tb/tb_zclk_gen.sv
// Directed bench for zclk_gen: mode table, 800-clk edge count, turbo switch, stall, contention, async reset.
module tb_zclk_gen;
  import zclk_pkg::*;

`ifdef ZCLK_CONTEND_EN
  localparam int CONT_EN = 1;
`else
  localparam int CONT_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       c1 = 1'b0, c3 = 1'b0;
  logic [1:0] turbo = 2'b00;
  logic       zstall = 1'b0, cont = 1'b0, cont_win = 1'b0;
  logic       zclk_out, zpos, zneg;
  logic [1:0] turbo_cur;

  logic [1:0] t_turbo = 2'b00;
  logic       t_zstall = 1'b0, t_cont = 1'b0, t_cw = 1'b0;
  int         ph = 0;
  int         c1_seen = 0;
  logic [1:0] first_tc = 2'b00;

  int n_tests = 0, n_fail = 0;
  int overlap_cnt = 0, alt_err = 0;
  logic last_pos = 1'b1;

  typedef struct {
    logic [1:0] turbo;
    logic [1:0] exp_cur;
    int         exp_hi;
    int         exp_lo;
  } vec_t;
  vec_t vecs[5];

  zclk_gen dut (
    .clk(clk), .rst_n(rst_n), .c1(c1), .c3(c3), .turbo(turbo),
    .zstall(zstall), .cont(cont), .cont_win(cont_win),
    .zclk_out(zclk_out), .zpos(zpos), .zneg(zneg), .turbo_cur(turbo_cur)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Strobe hygiene: never both at once, and strictly alternating starting with zneg.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pos = 1'b1;
    end else if (zpos && zneg) begin
      overlap_cnt++;
    end else if (zpos) begin
      if (last_pos) alt_err++;
      last_pos = 1'b1;
    end else if (zneg) begin
      if (!last_pos) alt_err++;
      last_pos = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    ph       = (ph + 1) % 4;
    c1       = (ph == 1);
    c3       = (ph == 3);
    turbo    = t_turbo;
    zstall   = t_zstall;
    cont     = t_cont;
    cont_win = t_cw;
    #3;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ev(input bit want_pos, output int n);
    n = -1;
    c1_seen = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (i == 1) first_tc = turbo_cur;
      if (c1) c1_seen++;
      if (want_pos ? zpos : zneg) begin
        n = i;
        return;
      end
    end
    chk(want_pos ? "timeout_zpos" : "timeout_zneg", 0, 1);
  endtask

  initial begin
    int n, hi, lo, np, nn, bad, first_neg;

    vecs[0] = '{turbo: 2'b00, exp_cur: 2'b00, exp_hi: 4, exp_lo: 4};
    vecs[1] = '{turbo: 2'b01, exp_cur: 2'b01, exp_hi: 2, exp_lo: 2};
    vecs[2] = '{turbo: 2'b10, exp_cur: 2'b10, exp_hi: 1, exp_lo: 1};
    vecs[3] = '{turbo: 2'b11, exp_cur: 2'b10, exp_hi: 1, exp_lo: 1};
    vecs[4] = '{turbo: 2'b00, exp_cur: 2'b00, exp_hi: 4, exp_lo: 4};

    // Reset: c1 pulses while rst_n is low, strobes must stay gated.
    cyc();
    chk("rst_c1_phase", int'(c1), 1);
    chk("rst_zclk", int'(zclk_out), 1);
    chk("rst_zpos", int'(zpos), 0);
    chk("rst_zneg", int'(zneg), 0);
    chk("rst_turbo_cur", int'(turbo_cur), 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // 3.5 MHz: 800 clk gives 100 edges of each kind, all on c1.
    np = 0; nn = 0; bad = 0; first_neg = -1;
    for (int i = 1; i <= 800; i++) begin
      cyc();
      if (zpos) np++;
      if (zneg) begin
        nn++;
        if (first_neg < 0) first_neg = i;
      end
      if ((zpos || zneg) && !c1) bad++;
    end
    chk("first_zneg_cycle", first_neg, 2);
    chk("zpos_count_800", np, 100);
    chk("zneg_count_800", nn, 100);
    chk("edge_off_c1", bad, 0);

    // Mode table: load on zpos, settle one period, then measure high and low.
    for (int v = 0; v < 5; v++) begin
      t_turbo = vecs[v].turbo;
      wait_ev(1'b1, n);
      wait_ev(1'b0, n);
      wait_ev(1'b1, n);
      chk("zclk_low_at_zpos", int'(zclk_out), 0);
      wait_ev(1'b0, hi);
      chk("turbo_cur", int'(first_tc), int'(vecs[v].exp_cur));
      chk("high_len", hi, vecs[v].exp_hi);
      chk("zclk_high_at_zneg", int'(zclk_out), 1);
      if (vecs[v].turbo == 2'b00) chk("zneg_on_c1", int'(c1), 1);
      wait_ev(1'b1, lo);
      chk("low_len", lo, vecs[v].exp_lo);
    end

    // Turbo 00 -> 10 requested mid-low: low phase still ends on c1.
    wait_ev(1'b0, n);
    t_turbo = 2'b10;
    cyc();
    chk("sw_cur_still_3m5", int'(turbo_cur), 0);
    wait_ev(1'b1, n);
    chk("sw_low_remaining", n, 3);
    chk("sw_zpos_on_c1", int'(c1), 1);
    wait_ev(1'b0, hi);
    chk("sw_turbo_cur", int'(first_tc), 2);
    chk("sw_high_len", hi, 1);
    wait_ev(1'b1, lo);
    chk("sw_low_len", lo, 1);

    // Stall raised during low phase at 3.5 MHz, held 20 clk.
    t_turbo = 2'b00;
    wait_ev(1'b1, n);
    wait_ev(1'b0, n);
    t_zstall = 1'b1;
    np = 0; nn = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (zpos) np++;
      if (zneg) nn++;
    end
    chk("stall_zpos", np, 1);
    chk("stall_zneg", nn, 0);
    chk("stall_zclk_high", int'(zclk_out), 1);
    t_zstall = 1'b0;
    wait_ev(1'b0, n);
    chk("stall_release_first_c1", c1_seen, 1);

    // Contention at 3.5 MHz for 12 clk starting at the top of a high phase.
    wait_ev(1'b1, n);
    t_cont = 1'b1; t_cw = 1'b1;
    nn = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (zneg) nn++;
    end
    chk("cont_3m5_zneg", nn, (CONT_EN != 0) ? 0 : 2);
    t_cont = 1'b0; t_cw = 1'b0;
    wait_ev(1'b0, n);
    chk("cont_release_c1s", c1_seen, (CONT_EN != 0) ? 1 : 2);
    chk("cont_release_on_c1", int'(c1), 1);

    // Contention at 7 MHz never holds.
    t_turbo = 2'b01;
    wait_ev(1'b1, n);
    t_cont = 1'b1; t_cw = 1'b1;
    nn = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (zneg) nn++;
    end
    chk("cont_7m_zneg", nn, 3);
    t_cont = 1'b0; t_cw = 1'b0;

    // Asynchronous reset in the low phase at 14 MHz.
    t_turbo = 2'b10;
    wait_ev(1'b1, n);
    wait_ev(1'b0, n);
    @(posedge clk);
    #2;
    chk("pre_rst_zclk_low", int'(zclk_out), 0);
    chk("pre_rst_turbo", int'(turbo_cur), 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_zclk", int'(zclk_out), 1);
    chk("async_rst_turbo", int'(turbo_cur), 0);
    chk("async_rst_zpos", int'(zpos), 0);
    chk("async_rst_zneg", int'(zneg), 0);
    t_turbo = 2'b00;
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_ev(1'b0, n);
    chk("post_rst_zneg_on_c1", int'(c1), 1);
    chk("post_rst_zneg_first_c1", c1_seen, 1);

    chk("no_overlap", overlap_cnt, 0);
    chk("alternation", alt_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zclk_gen.md
# zclk_gen

Z80 CPU clock generator fed by the 28 MHz strobe generator. It builds the CPU clock pin waveform at 3.5, 7 or 14 MHz from the 7 MHz quarter-phase strobes, and emits single-cycle edge strobes so other blocks can act on CPU clock edges. It also holds the CPU clock high on request for wait states and contended memory, and changes turbo mode only at glitch-free points. It sits between the strobe generator and the Z80 bus interface and memory arbiter.

## Interface
- No parameters.
- clk  in  1  28 MHz system clock
- rst_n  in  1  asynchronous, active-low reset
- c1  in  1  7 MHz strobe, phase 90 (high one clk in four)
- c3  in  1  7 MHz strobe, phase 270
- turbo  in  2  requested speed: 00 = 3.5 MHz, 01 = 7 MHz, 10/11 = 14 MHz
- zstall  in  1  hold CPU clock high (wait/arbiter stall)
- cont  in  1  current CPU access targets contended memory
- cont_win  in  1  video timing reports the current slot as contended
- zclk_out  out  1  CPU clock pin, registered
- zpos  out  1  strobe: zclk_out rises at the end of this clk cycle
- zneg  out  1  strobe: zclk_out falls at the end of this clk cycle
- turbo_cur  out  2  turbo mode currently in effect

## Operation
- Toggle enable `te`, selected by `turbo_q`:
  - 00: te = c1 (toggle every 4 clk, period 8 clk = 3.5 MHz)
  - 01: te = c1 | c3 (period 4 clk = 7 MHz)
  - 1x: te = 1 (period 2 clk = 14 MHz)
- `hold` = zstall | contention hold (see Configuration).
- zneg = te & zclk_q & ~hold
- zpos = te & ~zclk_q
- zclk_q toggles on the clk edge ending a zpos or zneg cycle.
- Stall only extends the high phase. A low phase always completes.
  - If zstall rises during the low phase, the next rise still occurs and the clock then holds high.
- After hold drops, zneg fires on the first following te. The high phase is therefore never shorter than one te interval.
- turbo_q loads turbo only on a zpos cycle. The new mode governs the high phase that starts then.
  - A turbo change while the clock is low or held has no effect until the next zpos.
- turbo 11 is treated exactly as 10.
- turbo_cur = turbo_q.

## Timing
- Reset values: zclk_q = 1, turbo_q = 00, zpos = 0, zneg = 0.
  - zpos and zneg are gated low during reset.
  - First zneg is the first te after rst_n deasserts with hold = 0.
- zpos and zneg are combinational from registers and inputs. zclk_out changes exactly one clk after the strobe cycle begins.
- zpos and zneg are never high in the same cycle. They strictly alternate.
- 3.5 MHz: zclk_out high 4 clk, low 4 clk, falling edge aligned to c1.
- 7 MHz: 2 clk high / 2 clk low.
- 14 MHz: 1 clk high / 1 clk low.
- Reset mid-phase: zclk_out returns to 1 asynchronously and mode drops to 3.5 MHz. No partial pulse is generated afterwards.

## Configuration
- ZCLK_CONTEND_EN defined:
  - Contention hold = cont & cont_win & (turbo_q == 00).
  - This hold ORs into `hold`, so zneg is suppressed while both cont and cont_win are high in 3.5 MHz mode.
- ZCLK_CONTEND_EN undefined:
  - cont and cont_win are present but ignored. hold = zstall.
  - Ports are unchanged so the top level needs no edits.

## Structure
- Shared package zclk_pkg holds TURBO_3M5 = 2'b00, TURBO_7M = 2'b01 and TURBO_14M = 2'b10, plus a 2-bit turbo_t typedef.
- The Z80 bus interface and arbiter import the same package.
- Single module, no sub-module. The te mux and edge logic are small enough to keep inline.

## Test plan
- Reset, turbo = 00, no hold:
  - zclk_out toggles on every c1; period 8 clk.
  - zneg coincides with c1 while high; zpos with c1 while low.
  - 100 zpos and 100 zneg in 800 clk.
- turbo = 01, then 10: measured periods are 4 and 2 clk. zpos and zneg are never simultaneous.
- Switch turbo 00 -> 10 while zclk_out is low:
  - Low phase still ends at c1.
  - turbo_cur changes on that zpos.
  - Subsequent period is 2 clk.
- zstall asserted while zclk_out is low, held 20 clk:
  - One zpos still occurs, then zclk_out stays high with no zneg.
  - zneg fires on the first te after release.
- With ZCLK_CONTEND_EN, turbo = 00, cont = cont_win = 1 for 12 clk: falling edge is delayed to the first c1 after cont_win drops.
  - Repeat at turbo = 01: no delay.
  - Repeat without the macro: no delay.
- Assert rst_n low mid-low-phase at 14 MHz: zclk_out = 1 and turbo_cur = 00 immediately.
